// File: rtl/fifo_reader_pkg.sv
// fifo_reader_pkg: shared widths, types and the pop-credit rule for the FIFO read-side drain engine
package fifo_reader_pkg;
  localparam int FIFO_W = 8;
  typedef logic [FIFO_W-1:0] fifo_word_t;
  typedef logic [1:0] occ_t;
  // Words already owed to the buffer after this edge must stay below its 2 slots
  function automatic logic has_credit(occ_t occ, logic inflight, logic pop);
    return ({1'b0, occ} + {2'b0, inflight} - {2'b0, pop}) < 3'd2;
  endfunction
endpackage

// File: rtl/fifo_reader_if.sv
// fifo_reader_if: FIFO read port plus downstream valid/ready stream; master is the reader side
interface fifo_reader_if
  import fifo_reader_pkg::*;
#(parameter int WIDTH = FIFO_W);
  logic fifo_empty;
  logic fifo_read_en;
  logic [WIDTH-1:0] fifo_data;
  logic m_valid;
  logic m_ready;
  logic [WIDTH-1:0] m_data;
  modport master(input fifo_empty, fifo_data, m_ready, output fifo_read_en, m_valid, m_data);
  modport slave(output fifo_empty, fifo_data, m_ready, input fifo_read_en, m_valid, m_data);
endinterface

// File: rtl/fifo_reader_skid.sv
// fifo_reader_skid: 2-entry in-order skid buffer; e0 is the head, e1 holds the word queued behind it
module fifo_reader_skid
  import fifo_reader_pkg::*;
#(parameter int WIDTH = FIFO_W) (
  input  logic             clock,
  input  logic             reset,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             pop,
  output occ_t             occ,
  output logic [WIDTH-1:0] head
);
  occ_t occ_q, occ_d, base;
  logic [WIDTH-1:0] e0_q, e0_d, e1_q, e1_d;
  // base is the occupancy left after the pop; a write lands in the first free slot
  always_comb begin
    base = occ_q - occ_t'(pop);
    occ_d = base + occ_t'(wr_en);
    e0_d = (wr_en && base == 2'd0) ? wr_data : pop ? e1_q : e0_q;
    e1_d = (wr_en && base == 2'd1) ? wr_data : e1_q;
  end
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      occ_q <= '0;
      e0_q <= '0;
      e1_q <= '0;
    end else begin
      occ_q <= occ_d;
      e0_q <= e0_d;
      e1_q <= e1_d;
    end
  end
  assign occ = occ_q;
  assign head = e0_q;
endmodule

// File: rtl/fifo_reader.sv
// fifo_reader: pops the FIFO under a 2-word credit, absorbs its 1-cycle read latency, re-presents words on valid/ready.
// FIFO_READER_STATS_EN adds the CNT_W parameter and the word_count delivered-word counter.
module fifo_reader
  import fifo_reader_pkg::*;
#(
  parameter int WIDTH = FIFO_W
`ifdef FIFO_READER_STATS_EN
  , parameter int CNT_W = 16
`endif
) (
  input logic clock,
  input logic reset,
  input logic enable,
  fifo_reader_if.master bus
`ifdef FIFO_READER_STATS_EN
  , output logic [CNT_W-1:0] word_count
`endif
);
  occ_t occ;
  logic [WIDTH-1:0] head;
  logic m_valid, pop_out, rd_en, inflight_q, inflight_d;
  assign m_valid = occ != 2'd0;
  assign pop_out = m_valid && bus.m_ready;
  // m_ready reaches rd_en combinationally so a full buffer can refill on the cycle it drains
  assign rd_en = !reset && enable && !bus.fifo_empty && has_credit(occ, inflight_q, pop_out);
  always_comb inflight_d = rd_en;
  always_ff @(posedge clock or posedge reset) begin
    if (reset) inflight_q <= 1'b0;
    else inflight_q <= inflight_d;
  end
  fifo_reader_skid #(.WIDTH(WIDTH)) u_skid (
    .clock(clock),
    .reset(reset),
    .wr_en(inflight_q),
    .wr_data(bus.fifo_data),
    .pop(pop_out),
    .occ(occ),
    .head(head)
  );
  assign bus.fifo_read_en = rd_en;
  assign bus.m_valid = m_valid;
  assign bus.m_data = head;
`ifdef FIFO_READER_STATS_EN
  logic [CNT_W-1:0] word_count_q, word_count_d;
  always_comb word_count_d = word_count_q + CNT_W'(pop_out);
  always_ff @(posedge clock or posedge reset) begin
    if (reset) word_count_q <= '0;
    else word_count_q <= word_count_d;
  end
  assign word_count = word_count_q;
`endif
endmodule
